// File: rtl/serial_crc8_checker.sv
// Bit-serial CRC-8 frame checker: DATA_BITS payload bits then an 8-bit CRC, MSB first.
// Reports the match result with a one-cycle done/crc_ok/crc_err pulse.
module serial_crc8_checker #(
  parameter int          DATA_BITS = 16,
  parameter logic [7:0]  POLY      = 8'h07,
  parameter logic [7:0]  INIT      = 8'h00
) (
  input  logic       CK,
  input  logic       RS,
  input  logic       start,
  input  logic       din,
  input  logic       din_vld,
  output logic       busy,
  output logic       done,
  output logic       crc_ok,
  output logic       crc_err,
  output logic [7:0] crc_out,
  output logic [1:0] state_dbg_o
);

  // Handshake: din is consumed on every cycle with din_vld=1 while in DATA or CHECK;
  // din_vld=0 freezes the frame for any number of cycles. There is no back-pressure.

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DATA  = 2'b01,
    CHECK = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Counter must reach DATA_BITS-1 and also index the 8 CRC bits.
  localparam int CW = ($clog2(DATA_BITS) > 3) ? $clog2(DATA_BITS) : 3;
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_CRC  = CW'(7);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    crc_q, crc_d;
  logic          mism_q, mism_d;
  logic          fb;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    mism_d  = mism_q;
    fb      = crc_q[7] ^ din;
    case (state_q)
      IDLE: begin
        if (start) begin
          crc_d   = INIT;
          cnt_d   = '0;
          mism_d  = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (din_vld) begin
          crc_d = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
          if (cnt_q == LAST_DATA) begin
            cnt_d   = '0;
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      CHECK: begin
        if (din_vld) begin
          // The current bit is folded in so the last CRC bit is not missed.
          mism_d = mism_q | (din ^ crc_q[3'd7 - cnt_q[2:0]]);
          if (cnt_q == LAST_CRC) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RS) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crc_q   <= 8'h00;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      mism_q  <= mism_d;
    end
  end

  // Result outputs are decoded from registered state only.
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign crc_ok      = done & ~mism_q;
  assign crc_err     = done & mism_q;
  assign crc_out     = crc_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_serial_crc8_checker.sv
// Directed testbench for serial_crc8_checker with default parameters (16-bit payload, POLY 0x07).
// Expected CRCs and pulse cycles are hand-computed constants.
module tb_serial_crc8_checker;

  logic       CK = 1'b0;
  logic       RS, start, din, din_vld;
  logic       busy, done, crc_ok, crc_err;
  logic [7:0] crc_out;
  logic [1:0] state_dbg_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Frame monitor state, updated every cycle by step_mon.
  int         mon_done_cyc;
  int         mon_pulses;
  int         mon_flag_pulses;
  logic [7:0] mon_crc;
  logic       mon_ok, mon_err, mon_busy_after, mon_prev_done;
  bit         mon_poke;

  serial_crc8_checker dut (
    .CK(CK), .RS(RS), .start(start), .din(din), .din_vld(din_vld),
    .busy(busy), .done(done), .crc_ok(crc_ok), .crc_err(crc_err),
    .crc_out(crc_out), .state_dbg_o(state_dbg_o)
  );

  // Clock / watchdog
  always #5 CK = ~CK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Inputs change and outputs are read 1 time unit after each rising edge.
  task automatic step();
    @(posedge CK);
    #1;
    cyc++;
  endtask

  task automatic step_mon();
    step();
    if (mon_prev_done) mon_busy_after = busy;
    mon_prev_done = done;
    if (crc_ok | crc_err) mon_flag_pulses++;
    start = 1'b0;
    if (done) begin
      mon_pulses++;
      mon_done_cyc = cyc;
      mon_crc = crc_out;
      mon_ok = crc_ok;
      mon_err = crc_err;
      if (mon_poke) start = 1'b1;
    end
  endtask

  // Drives one frame starting in IDLE; stalls insert din_vld=0 cycles before the given bit.
  task automatic run_frame(input logic [15:0] pl, input logic [7:0] c,
                           input int dstall_at, input int dstall_n,
                           input int cstall_at, input int cstall_n, input bit poke);
    mon_done_cyc = -1; mon_pulses = 0; mon_flag_pulses = 0;
    mon_crc = 8'hxx; mon_ok = 1'bx; mon_err = 1'bx; mon_busy_after = 1'bx;
    mon_prev_done = 1'b0; mon_poke = poke;
    cyc = 0;
    start = 1'b1; din = 1'($urandom_range(0, 1)); din_vld = 1'($urandom_range(0, 1));
    step_mon();
    for (int i = 0; i < 16; i++) begin
      if (i == dstall_at) begin
        repeat (dstall_n) begin
          din_vld = 1'b0; din = 1'($urandom_range(0, 1));
          step_mon();
        end
      end
      din = pl[15-i]; din_vld = 1'b1;
      if (poke && i == 8) start = 1'b1;
      step_mon();
    end
    for (int i = 0; i < 8; i++) begin
      if (i == cstall_at) begin
        repeat (cstall_n) begin
          din_vld = 1'b0; din = 1'($urandom_range(0, 1));
          step_mon();
        end
      end
      din = c[7-i]; din_vld = 1'b1;
      step_mon();
    end
    din_vld = 1'b0;
    repeat (4) step_mon();
  endtask

  task automatic test_reset();
    RS = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start = 1'($urandom_range(0, 1)); din = 1'($urandom_range(0, 1));
      din_vld = 1'($urandom_range(0, 1));
      step();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
      vectors++; if (crc_ok !== 1'b0) begin miscompares++; $display("FAIL reset_ok: got %b want 0", crc_ok); end
      vectors++; if (crc_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", crc_err); end
      vectors++; if (crc_out !== 8'h00) begin miscompares++; $display("FAIL reset_crc: got %h want 00", crc_out); end
      vectors++; if (state_dbg_o !== 2'b00) begin miscompares++; $display("FAIL reset_state: got %b want 00", state_dbg_o); end
    end
    RS = 1'b0; start = 1'b0; din_vld = 1'b0;
    step();
  endtask

  task automatic test_basic();
    run_frame(16'h0001, 8'h07, -1, 0, -1, 0, 1'b0);
    vectors++; if (mon_done_cyc !== 25) begin miscompares++; $display("FAIL basic_done_cycle: got %0d want 25", mon_done_cyc); end
    vectors++; if (mon_pulses !== 1) begin miscompares++; $display("FAIL basic_done_pulses: got %0d want 1", mon_pulses); end
    vectors++; if (mon_flag_pulses !== 1) begin miscompares++; $display("FAIL basic_flag_pulses: got %0d want 1", mon_flag_pulses); end
    vectors++; if (mon_crc !== 8'h07) begin miscompares++; $display("FAIL basic_crc: got %h want 07", mon_crc); end
    vectors++; if (mon_ok !== 1'b1) begin miscompares++; $display("FAIL basic_ok: got %b want 1", mon_ok); end
    vectors++; if (mon_err !== 1'b0) begin miscompares++; $display("FAIL basic_err: got %b want 0", mon_err); end
    vectors++; if (mon_busy_after !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b want 0", mon_busy_after); end
    vectors++; if (crc_out !== 8'h07) begin miscompares++; $display("FAIL basic_crc_hold: got %h want 07", crc_out); end
  endtask

  task automatic test_crc_match();
    run_frame(16'h0100, 8'h15, -1, 0, -1, 0, 1'b0);
    vectors++; if (mon_done_cyc !== 25) begin miscompares++; $display("FAIL match_done_cycle: got %0d want 25", mon_done_cyc); end
    vectors++; if (mon_crc !== 8'h15) begin miscompares++; $display("FAIL match_crc: got %h want 15", mon_crc); end
    vectors++; if (mon_ok !== 1'b1) begin miscompares++; $display("FAIL match_ok: got %b want 1", mon_ok); end
    vectors++; if (mon_err !== 1'b0) begin miscompares++; $display("FAIL match_err: got %b want 0", mon_err); end
  endtask

  task automatic test_last_bit_error();
    run_frame(16'h0100, 8'h14, -1, 0, -1, 0, 1'b0);
    vectors++; if (mon_pulses !== 1) begin miscompares++; $display("FAIL lastbit_done_pulses: got %0d want 1", mon_pulses); end
    vectors++; if (mon_crc !== 8'h15) begin miscompares++; $display("FAIL lastbit_crc: got %h want 15", mon_crc); end
    vectors++; if (mon_ok !== 1'b0) begin miscompares++; $display("FAIL lastbit_ok: got %b want 0", mon_ok); end
    vectors++; if (mon_err !== 1'b1) begin miscompares++; $display("FAIL lastbit_err: got %b want 1", mon_err); end
  endtask

  task automatic test_stall();
    run_frame(16'h0100, 8'h15, 6, 3, 3, 2, 1'b0);
    vectors++; if (mon_done_cyc !== 30) begin miscompares++; $display("FAIL stall_done_cycle: got %0d want 30", mon_done_cyc); end
    vectors++; if (mon_pulses !== 1) begin miscompares++; $display("FAIL stall_done_pulses: got %0d want 1", mon_pulses); end
    vectors++; if (mon_crc !== 8'h15) begin miscompares++; $display("FAIL stall_crc: got %h want 15", mon_crc); end
    vectors++; if (mon_ok !== 1'b1) begin miscompares++; $display("FAIL stall_ok: got %b want 1", mon_ok); end
    vectors++; if (mon_err !== 1'b0) begin miscompares++; $display("FAIL stall_err: got %b want 0", mon_err); end
  endtask

  task automatic test_ignored_start();
    run_frame(16'h0001, 8'h07, -1, 0, -1, 0, 1'b1);
    vectors++; if (mon_done_cyc !== 25) begin miscompares++; $display("FAIL istart_done_cycle: got %0d want 25", mon_done_cyc); end
    vectors++; if (mon_pulses !== 1) begin miscompares++; $display("FAIL istart_done_pulses: got %0d want 1", mon_pulses); end
    vectors++; if (mon_ok !== 1'b1) begin miscompares++; $display("FAIL istart_ok: got %b want 1", mon_ok); end
    vectors++; if (mon_busy_after !== 1'b0) begin miscompares++; $display("FAIL istart_busy_after: got %b want 0", mon_busy_after); end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] pl;
    pl = 16'hFFFF;
    start = 1'b1; din_vld = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      din = pl[15-i]; din_vld = 1'b1;
      step();
    end
    vectors++; if (crc_out !== 8'hE6) begin miscompares++; $display("FAIL rmid_crc_pre: got %h want e6", crc_out); end
    vectors++; if (state_dbg_o !== 2'b01) begin miscompares++; $display("FAIL rmid_state_pre: got %b want 01", state_dbg_o); end
    din = pl[6]; din_vld = 1'b1; RS = 1'b1;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rmid_done: got %b want 0", done); end
    vectors++; if (crc_ok !== 1'b0) begin miscompares++; $display("FAIL rmid_ok: got %b want 0", crc_ok); end
    vectors++; if (crc_err !== 1'b0) begin miscompares++; $display("FAIL rmid_err: got %b want 0", crc_err); end
    vectors++; if (crc_out !== 8'h00) begin miscompares++; $display("FAIL rmid_crc: got %h want 00", crc_out); end
    RS = 1'b0; din_vld = 1'b0;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy_after: got %b want 0", busy); end
    run_frame(16'h0001, 8'h07, -1, 0, -1, 0, 1'b0);
    vectors++; if (mon_done_cyc !== 25) begin miscompares++; $display("FAIL rmid_fresh_done_cycle: got %0d want 25", mon_done_cyc); end
    vectors++; if (mon_crc !== 8'h07) begin miscompares++; $display("FAIL rmid_fresh_crc: got %h want 07", mon_crc); end
    vectors++; if (mon_ok !== 1'b1) begin miscompares++; $display("FAIL rmid_fresh_ok: got %b want 1", mon_ok); end
  endtask

  initial begin
    RS = 1'b1; start = 1'b0; din = 1'b0; din_vld = 1'b0;
    test_reset();
    test_basic();
    test_crc_match();
    test_last_bit_error();
    test_stall();
    test_ignored_start();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
